// File: rtl/stepper_ramp_controller_pkg.sv
// Shared definitions for the stepper ramp controller: state encoding and default widths.
// The encoding values are fixed so a multi-axis scheduler can decode them.
package stepper_ramp_controller_pkg;

    localparam int unsigned DefCountBits = 32;
    localparam int unsigned DefStepBits  = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccel  = 2'd1,
        StCruise = 2'd2,
        StDecel  = 2'd3
    } state_e;

endpackage

// File: rtl/stepper_ramp_controller_if.sv
// Command / status bundle between the host registers, the rate divider and one axis controller.
interface stepper_ramp_controller_if
    import stepper_ramp_controller_pkg::*;
#(
    parameter int unsigned COUNT_BITS = DefCountBits,
    parameter int unsigned STEP_BITS  = DefStepBits
) ();

    logic                  start;
    logic                  abort;
    logic [STEP_BITS-1:0]  steps;
    logic [COUNT_BITS-1:0] max_rate;
    logic [COUNT_BITS-1:0] accel;
    logic                  ramp_clk;
    logic                  step_pulse;
    logic [COUNT_BITS-1:0] rate;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic [STEP_BITS-1:0]  remaining;

    // Host / divider side
    modport master (
        output start, abort, steps, max_rate, accel, ramp_clk, step_pulse,
        input  rate, busy, done, aborted, remaining
    );

    // Controller side
    modport slave (
        input  start, abort, steps, max_rate, accel, ramp_clk, step_pulse,
        output rate, busy, done, aborted, remaining
    );

endinterface

// File: rtl/stepper_ramp_controller_edge_detector.sv
// Rising-edge detector: one register of history, pulse is high for the first clk cycle
// in which the input is seen high.
module stepper_ramp_controller_edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // Remember last cycle's level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    // Rise = high now, low last cycle
    always_comb begin
        rise = sig & ~sig_q;
    end

endmodule

// File: rtl/stepper_ramp_controller.sv
// Single-axis trapezoidal ramp controller. Drives the divider rate word, counts the
// divider's step pulses back and decelerates early enough to stop on the exact count.
module stepper_ramp_controller
    import stepper_ramp_controller_pkg::*;
#(
    parameter int unsigned COUNT_BITS = DefCountBits,
    parameter int unsigned STEP_BITS  = DefStepBits
) (
    input logic                       clk,
    input logic                       rst,
    stepper_ramp_controller_if.slave  bus
);

    state_e                state_q, state_d;
    logic [COUNT_BITS-1:0] rate_q, rate_d;
    logic [COUNT_BITS-1:0] max_rate_q, max_rate_d;
    logic [COUNT_BITS-1:0] accel_q, accel_d;
    logic [STEP_BITS-1:0]  remaining_q, remaining_d;
    logic [STEP_BITS-1:0]  ramp_steps_q, ramp_steps_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;

    logic                  tick;
    logic [STEP_BITS-1:0]  rem_step, rs_step, rem_abort;
    logic [COUNT_BITS:0]   rate_sum;
    logic [COUNT_BITS-1:0] rate_up, rate_sub, rate_dn;

    stepper_ramp_controller_edge_detector u_ramp_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (bus.ramp_clk),
        .rise (tick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; rate clears asynchronously so the divider stops on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_q       <= '0;
            max_rate_q   <= '0;
            accel_q      <= '0;
            remaining_q  <= '0;
            ramp_steps_q <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            rate_q       <= rate_d;
            max_rate_q   <= max_rate_d;
            accel_q      <= accel_d;
            remaining_q  <= remaining_d;
            ramp_steps_q <= ramp_steps_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    // Next state and datapath: command accept, step accounting, ramp, decel trigger, completion
    always_comb begin
        state_d      = state_q;
        rate_d       = rate_q;
        max_rate_d   = max_rate_q;
        accel_d      = accel_q;
        remaining_d  = remaining_q;
        ramp_steps_d = ramp_steps_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;

        // Post-step counters; ramp_steps only grows while accelerating
        rem_step  = remaining_q - {{(STEP_BITS-1){1'b0}}, bus.step_pulse};
        rs_step   = ramp_steps_q
                  + {{(STEP_BITS-1){1'b0}}, bus.step_pulse & (state_q == StAccel)};
        rem_abort = (rem_step < rs_step) ? rem_step : rs_step;

        // Saturating ramp arithmetic; sum is one bit wider so overflow cannot wrap
        rate_sum = {1'b0, rate_q} + {1'b0, accel_q};
        rate_up  = (rate_sum >= {1'b0, max_rate_q}) ? max_rate_q : rate_sum[COUNT_BITS-1:0];
        rate_sub = (rate_q > accel_q) ? (rate_q - accel_q) : '0;
        rate_dn  = (rate_sub > accel_q) ? rate_sub : accel_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    aborted_d = 1'b0;
                    if ((bus.steps == '0) || (bus.max_rate == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        max_rate_d   = bus.max_rate;
                        accel_d      = bus.accel;
                        remaining_d  = bus.steps;
                        ramp_steps_d = '0;
                        if ((bus.accel == '0) || (bus.accel >= bus.max_rate)) begin
                            rate_d  = bus.max_rate;
                            state_d = StCruise;
                        end else begin
                            rate_d  = bus.accel;
                            state_d = StAccel;
                        end
                    end
                end
            end
            default: begin
                remaining_d  = rem_step;
                ramp_steps_d = rs_step;
                if (tick && (state_q == StAccel)) begin
                    rate_d = rate_up;
                    if (rate_up == max_rate_q) begin
                        state_d = StCruise;
                    end
                end else if (tick && (state_q == StDecel)) begin
                    rate_d = rate_dn;
                end
                if (bus.abort) begin
                    remaining_d = rem_abort;
                    aborted_d   = 1'b1;
                    state_d     = StDecel;
                end
                // Stopping distance reached: overrides an ACCEL->CRUISE move this cycle
                if ((state_q != StDecel) && (remaining_d <= ramp_steps_d)) begin
                    state_d = StDecel;
                end
                // Last step issued: overrides any ramp update this cycle
                if (remaining_d == '0) begin
                    rate_d  = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Outputs straight from registers
    always_comb begin
        bus.rate      = rate_q;
        bus.busy      = (state_q != StIdle);
        bus.done      = done_q;
        bus.aborted   = aborted_q;
        bus.remaining = remaining_q;
    end

endmodule

// File: tb/tb_stepper_ramp_controller.sv
// Bench for stepper_ramp_controller: behavioural model compared every cycle plus
// hand-computed expectations for each directed move.
module tb_stepper_ramp_controller;

    localparam int unsigned CB = 32;
    localparam int unsigned SB = 32;
    localparam int M_IDLE   = 0;
    localparam int M_ACCEL  = 1;
    localparam int M_CRUISE = 2;
    localparam int M_DECEL  = 3;

    typedef struct {
        int     mode;
        longint rate;
        longint rem;
        longint rs;
        longint max_r;
        longint acc;
        longint steps_seen;
        bit     done;
        bit     aborted;
        bit     prev_ramp;
        bit     saw_cruise;
        bit     saw_decel;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic step_auto = 1'b0;
    logic step_man  = 1'b0;
    logic ramp_auto = 1'b0;
    int unsigned step_period = 0;
    int unsigned tick_period = 0;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;
    model_t m;
    longint rate_log[$];
    longint last_rate = 0;

    stepper_ramp_controller_if #(.COUNT_BITS(CB), .STEP_BITS(SB)) bus ();

    stepper_ramp_controller #(.COUNT_BITS(CB), .STEP_BITS(SB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.step_pulse = step_auto | step_man;
    assign bus.ramp_clk   = ramp_auto;

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Periodic step pulses (divider stand-in) and ramp timebase
    always @(negedge clk) begin
        cyc       <= cyc + 1;
        step_auto <= (step_period != 0) && ((cyc % step_period) == step_period - 1);
        ramp_auto <= (tick_period != 0) && ((cyc % tick_period) < tick_period / 2);
    end

    // Move rules evaluated on the inputs seen at a clock edge
    function automatic model_t model_next(input model_t s, input bit start, input bit abort,
                                          input bit step, input bit ramp, input longint n_steps,
                                          input longint n_max, input longint n_acc);
        model_t n = s;
        bit tk = ramp && !s.prev_ramp;
        n.prev_ramp = ramp;
        n.done = 0;
        if (s.mode == M_IDLE) begin
            if (start) begin
                n.aborted = 0;
                n.saw_cruise = 0;
                n.saw_decel = 0;
                n.steps_seen = 0;
                if (n_steps == 0 || n_max == 0) begin
                    n.done = 1;
                end else begin
                    n.max_r = n_max;
                    n.acc = n_acc;
                    n.rem = n_steps;
                    n.rs = 0;
                    if (n_acc == 0 || n_acc >= n_max) begin
                        n.rate = n_max;
                        n.mode = M_CRUISE;
                        n.saw_cruise = 1;
                    end else begin
                        n.rate = n_acc;
                        n.mode = M_ACCEL;
                    end
                end
            end
        end else begin
            if (step) begin
                n.rem = s.rem - 1;
                n.steps_seen = s.steps_seen + 1;
                if (s.mode == M_ACCEL) n.rs = s.rs + 1;
            end
            if (tk && s.mode == M_ACCEL) begin
                n.rate = (s.rate + s.acc > s.max_r) ? s.max_r : s.rate + s.acc;
                if (n.rate == s.max_r) n.mode = M_CRUISE;
            end
            if (tk && s.mode == M_DECEL) begin
                n.rate = (s.rate - s.acc > s.acc) ? s.rate - s.acc : s.acc;
            end
            if (abort) begin
                if (n.rs < n.rem) n.rem = n.rs;
                n.aborted = 1;
                n.mode = M_DECEL;
            end
            if ((s.mode == M_ACCEL || s.mode == M_CRUISE) && n.rem <= n.rs) n.mode = M_DECEL;
            if (n.rem == 0) begin
                n.rate = 0;
                n.done = 1;
                n.mode = M_IDLE;
            end
            if (n.mode == M_CRUISE) n.saw_cruise = 1;
            if (n.mode == M_DECEL) n.saw_decel = 1;
        end
        return n;
    endfunction

    function automatic model_t model_reset();
        model_t n;
        n.mode = M_IDLE;
        n.rate = 0;
        n.rem = 0;
        n.rs = 0;
        n.max_r = 0;
        n.acc = 0;
        n.steps_seen = 0;
        n.done = 0;
        n.aborted = 0;
        n.prev_ramp = 0;
        n.saw_cruise = 0;
        n.saw_decel = 0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= model_reset();
        end else begin
            m <= model_next(m, bus.start, bus.abort, bus.step_pulse, bus.ramp_clk,
                            longint'(bus.steps), longint'(bus.max_rate), longint'(bus.accel));
        end
    end

    // Every-cycle comparison against the model, plus a log of busy rate changes
    always @(negedge clk) begin
        if (!rst) begin
            check("rate", longint'(bus.rate), m.rate);
            check("busy", longint'(bus.busy), longint'(m.mode != M_IDLE));
            check("done", longint'(bus.done), longint'(m.done));
            check("aborted", longint'(bus.aborted), longint'(m.aborted));
            check("remaining", longint'(bus.remaining), m.rem);
            if (bus.busy && longint'(bus.rate) != last_rate) rate_log.push_back(longint'(bus.rate));
            last_rate <= bus.busy ? longint'(bus.rate) : 0;
        end
    end

    task automatic do_start(input longint n_steps, input longint n_max, input longint n_acc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.steps = SB'(n_steps);
        bus.max_rate = CB'(n_max);
        bus.accel = CB'(n_acc);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk);
        step_man = 1'b1;
        @(negedge clk);
        step_man = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        check(name, longint'(seen), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit ok;
        longint mn;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.steps = '0;
        bus.max_rate = '0;
        bus.accel = '0;
        repeat (2) @(negedge clk);
        check("reset_rate", longint'(bus.rate), 0);
        check("reset_busy", longint'(bus.busy), 0);
        check("reset_remaining", longint'(bus.remaining), 0);
        rst = 1'b0;

        // Zero-length move
        do_start(0, 100, 10);
        check("zero_done", longint'(bus.done), 1);
        check("zero_busy", longint'(bus.busy), 0);
        @(negedge clk);
        check("zero_done_one_cycle", longint'(bus.done), 0);
        check("zero_rate", longint'(bus.rate), 0);

        // Abort while idle does nothing
        pulse_abort();
        check("idle_abort", longint'(bus.aborted), 0);

        // Trapezoid
        step_period = 4;
        tick_period = 8;
        base = rate_log.size();
        do_start(20, 40, 10);
        check("trap_busy_rise", longint'(bus.busy), 1);
        wait_done("trap_done_seen", 400);
        check("trap_done_rate0", longint'(bus.rate), 0);
        check("trap_steps", m.steps_seen, 20);
        check("trap_r0", rate_log[base], 10);
        check("trap_r1", rate_log[base + 1], 20);
        check("trap_r2", rate_log[base + 2], 30);
        check("trap_r3", rate_log[base + 3], 40);
        mn = 1000;
        for (int i = base; i < rate_log.size(); i++) if (rate_log[i] < mn) mn = rate_log[i];
        check("trap_min_rate", mn, 10);
        check("trap_cruise", longint'(m.saw_cruise), 1);
        check("trap_decel", longint'(m.saw_decel), 1);

        // Triangle
        do_start(4, 1000, 10);
        wait_done("tri_done_seen", 200);
        check("tri_cruise", longint'(m.saw_cruise), 0);
        check("tri_decel", longint'(m.saw_decel), 1);
        check("tri_steps", m.steps_seen, 4);

        // No ramp; a second start mid-move is ignored
        base = rate_log.size();
        do_start(5, 50, 0);
        check("flat_rate", longint'(bus.rate), 50);
        do_start(999, 77, 3);
        check("flat_restart_ignored", longint'(bus.rate), 50);
        wait_done("flat_done_seen", 200);
        check("flat_decel", longint'(m.saw_decel), 0);
        check("flat_log", longint'(rate_log.size() - base), 1);
        check("flat_steps", m.steps_seen, 5);

        // Abort in cruise: 6 steps ramping up, cruise at 100 remaining, abort
        step_period = 0;
        tick_period = 0;
        repeat (2) @(negedge clk);
        do_start(106, 40, 10);
        repeat (6) pulse_step();
        check("abort_pre_remaining", longint'(bus.remaining), 100);
        tick_period = 8;
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.rate == 40) begin
                ok = 1;
                break;
            end
        end
        check("abort_reach_cruise", longint'(ok), 1);
        tick_period = 0;
        check("abort_cruise", longint'(m.saw_cruise), 1);
        pulse_abort();
        check("abort_remaining", longint'(bus.remaining), 6);
        check("abort_flag", longint'(bus.aborted), 1);
        check("abort_busy", longint'(bus.busy), 1);
        repeat (5) pulse_step();
        check("abort_not_done_yet", longint'(bus.busy), 1);
        pulse_step();
        check("abort_done", longint'(bus.done), 1);
        check("abort_sticky", longint'(bus.aborted), 1);
        do_start(0, 100, 10);
        check("abort_cleared", longint'(bus.aborted), 0);

        // Asynchronous reset mid-ACCEL
        step_period = 4;
        tick_period = 8;
        do_start(50, 1000, 10);
        repeat (10) @(negedge clk);
        check("pre_reset_busy", longint'(bus.busy), 1);
        check("pre_reset_rate_nz", longint'(bus.rate != 0), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rate", longint'(bus.rate), 0);
        check("async_busy", longint'(bus.busy), 0);
        check("async_remaining", longint'(bus.remaining), 0);
        @(negedge clk);
        rst = 1'b0;
        do_start(3, 50, 0);
        check("fresh_busy", longint'(bus.busy), 1);
        check("fresh_rate", longint'(bus.rate), 50);
        wait_done("fresh_done_seen", 100);
        check("fresh_steps", m.steps_seen, 3);

        step_period = 0;
        tick_period = 0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stepper_ramp_controller.md
Name: stepper_ramp_controller

Overview:
- Sequences one stepper axis by driving the rate word (multiplicand) of a reciprocal rate divider.
- Counts the divider's step pulses back in and ramps the rate up to a cruise value, holds it, then ramps down so the move stops at exactly the commanded step count.
- Sits between the host command registers and the per-axis reciprocal divider; one instance per axis.

Parameters:
COUNT_BITS, 32, width of rate, max_rate and accel (matches divider multiplicand width)
STEP_BITS, 32, width of step count and internal step counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle command strobe; honoured only in IDLE
abort  input  1  one-cycle strobe; requests controlled stop
steps  input  STEP_BITS  move length in steps, sampled on start
max_rate  input  COUNT_BITS  cruise rate word, sampled on start
accel  input  COUNT_BITS  rate increment per ramp tick, sampled on start
ramp_clk  input  1  ramp timebase, level signal; rising edge = one ramp tick
step_pulse  input  1  divider output, one clk wide per step
rate  output  COUNT_BITS  multiplicand to divider
busy  output  1  high in ACCEL/CRUISE/DECEL
done  output  1  one-cycle pulse at move end
aborted  output  1  sticky; set when a move ended via abort, cleared on next accepted start
remaining  output  STEP_BITS  steps still to issue

Behaviour:
- Reset (async, any state): state IDLE; rate=0, busy=0, done=0, aborted=0, remaining=0, ramp_steps=0.
- States: IDLE, ACCEL, CRUISE, DECEL.
- Registered outputs, all updates on posedge clk. done is high for exactly one cycle.
- ramp tick: the rising edge of ramp_clk, detected via edge_detector. Tick latency from the ramp_clk edge is the detector delay; no further pipelining.
- IDLE + start:
  - steps==0 or max_rate==0: no motion; done pulses the next cycle; stay IDLE.
  - accel==0: rate=max_rate, remaining=steps; go to CRUISE.
  - Otherwise: rate=min(accel,max_rate), remaining=steps, ramp_steps=0; go to ACCEL. If accel>=max_rate, go to CRUISE instead.
  - busy rises the cycle after start.
- start while busy: ignored. step_pulse in IDLE: ignored. abort in IDLE: ignored.
- step_pulse while busy: remaining -= 1. In ACCEL only, ramp_steps += 1.
- ACCEL on tick:
  - rate = rate+accel, computed at COUNT_BITS+1 width and saturated to max_rate.
  - If the result equals max_rate, go to CRUISE.
- DECEL trigger: from ACCEL or CRUISE, when the post-update remaining <= ramp_steps, go to DECEL. This check takes priority over the ACCEL to CRUISE transition in the same cycle.
- DECEL on tick: rate = max(rate-accel, accel). The floor of accel guarantees the move finishes.
- Completion: when post-update remaining==0 in any busy state:
  - rate=0, busy=0, done=1; go to IDLE.
  - This overrides any ramp update in the same cycle.
- Simultaneous step_pulse and tick in one cycle:
  - Both are applied.
  - Rate arithmetic uses the current state.
  - The transition check uses the post-update remaining and ramp_steps.
- abort while busy:
  - remaining = min(remaining, ramp_steps), aborted=1, go to DECEL.
  - If the resulting remaining==0, complete immediately: rate=0, done pulse.
- Reset mid-move: rate drops to 0 asynchronously, so the divider stops issuing steps.

Decomposition:
- Shared include (ramp_defs.v): state encoding localparams (IDLE=0, ACCEL=1, CRUISE=2, DECEL=3) and default width constants, reused by the future multi-axis scheduler.
- One sub-module: the existing edge_detector on ramp_clk. Saturating add/sub stays inline.

Test Plan:
- steps=0, max_rate=100 -> done pulses one cycle after start; busy stays 0; rate stays 0.
- steps=20, max_rate=40, accel=10, a tick every 8 clks, a step every 4 clks:
  - rate goes 10,20,30,40; CRUISE is entered.
  - DECEL starts when remaining<=ramp_steps.
  - rate never drops below 10.
  - Exactly 20 steps are counted; done fires on the 20th step and rate=0 in the same cycle.
- steps=4, max_rate=1000, accel=10 (triangle) -> CRUISE is never entered; ACCEL goes straight to DECEL; done after 4 steps.
- accel=0, steps=5, max_rate=50 -> rate=50 from the first busy cycle until done; no DECEL.
- abort in CRUISE with remaining=100 and ramp_steps=6 -> remaining=6; DECEL; done after 6 more steps; aborted=1; aborted clears on the next start.
- rst asserted mid-ACCEL, asynchronously between clk edges -> rate, busy, remaining are 0 immediately; start after release begins a fresh move.
